// File: rtl/maq_hn_pkg.sv
// -----------------------------------------------------------------------------
// maq_pkg : shared types and BCD helpers for the maq_hn hour stage.
//   BCD_MAX    - largest legal BCD digit (9)
//   bcd_t      - one BCD digit
//   bcd_pair_t - {tens, units} digit pair, tens padded to 4 bits
//   op_e       - per-cycle operation chosen by the priority decode
//   bcd_val    - binary value of a digit pair
//   bcd_inc    - modulo increment of a digit pair
//   bcd_dec    - modulo decrement of a digit pair
// -----------------------------------------------------------------------------
package maq_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t msd;
        bcd_t lsd;
    } bcd_pair_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_LOAD,
        OP_TICK,
        OP_UP,
        OP_DOWN
    } op_e;

    function automatic logic [7:0] bcd_val(input bcd_pair_t p);
        return 8'(8'(p.msd) * 8'd10 + 8'(p.lsd));
    endfunction

    // Terminal value (modulus-1) wraps both digits to zero.
    function automatic bcd_pair_t bcd_inc(input bcd_pair_t p, input logic [7:0] modulus);
        bcd_pair_t r;
        r = p;
        if (bcd_val(p) == modulus - 8'd1) begin
            r = '0;
        end else if (p.lsd == BCD_MAX) begin
            r.msd = p.msd + 4'd1;
            r.lsd = '0;
        end else begin
            r.lsd = p.lsd + 4'd1;
        end
        return r;
    endfunction

    // Zero wraps to modulus-1, split back into tens/units.
    function automatic bcd_pair_t bcd_dec(input bcd_pair_t p, input logic [7:0] modulus);
        bcd_pair_t r;
        r = p;
        if (bcd_val(p) == 8'd0) begin
            r.msd = 4'((modulus - 8'd1) / 8'd10);
            r.lsd = 4'((modulus - 8'd1) % 8'd10);
        end else if (p.lsd == 4'd0) begin
            r.msd = p.msd - 4'd1;
            r.lsd = BCD_MAX;
        end else begin
            r.lsd = p.lsd - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/maq_hn_if.sv
// -----------------------------------------------------------------------------
// maq_hn_if : control/display bundle of the maq_hn hour stage.
//   Controls in : enable_1hz, inc_m, inc_h, set_up, set_down, load,
//                 load_lsd, load_msd, mode_12h, alarm_set
//   Display out : maqh_lsd, maqh_msd, pm, carry_out, load_err, alarm_hit
//   master modport drives the controls, slave modport is the hour stage.
// -----------------------------------------------------------------------------
interface maq_hn_if #(
    parameter int MSD_W = 3
);
    logic             enable_1hz;
    logic             inc_m;
    logic             inc_h;
    logic             set_up;
    logic             set_down;
    logic             load;
    logic [3:0]       load_lsd;
    logic [MSD_W-1:0] load_msd;
    logic             mode_12h;
    logic             alarm_set;
    logic [3:0]       maqh_lsd;
    logic [MSD_W-1:0] maqh_msd;
    logic             pm;
    logic             carry_out;
    logic             load_err;
    logic             alarm_hit;

    modport master (
        output enable_1hz, inc_m, inc_h, set_up, set_down, load,
               load_lsd, load_msd, mode_12h, alarm_set,
        input  maqh_lsd, maqh_msd, pm, carry_out, load_err, alarm_hit
    );

    modport slave (
        input  enable_1hz, inc_m, inc_h, set_up, set_down, load,
               load_lsd, load_msd, mode_12h, alarm_set,
        output maqh_lsd, maqh_msd, pm, carry_out, load_err, alarm_hit
    );
endinterface

// File: rtl/maq_hn_h12conv.sv
// -----------------------------------------------------------------------------
// maq_h12conv : combinational 24h -> 12h BCD display converter.
//   i_msd/i_lsd : canonical 24h tens/units digits
//   i_mode      : 1 = 12h format, 0 = pass-through
//   o_msd/o_lsd : displayed tens/units digits
//   o_pm        : PM flag (only in 12h format)
// -----------------------------------------------------------------------------
module maq_h12conv
    import maq_pkg::*;
#(
    parameter int MSD_W = 3
) (
    input  logic [MSD_W-1:0] i_msd,
    input  bcd_t             i_lsd,
    input  logic             i_mode,
    output logic [MSD_W-1:0] o_msd,
    output bcd_t             o_lsd,
    output logic             o_pm
);
    logic [6:0] w_val;
    logic [6:0] w_disp;

    always_comb begin
        w_val  = 7'(7'(i_msd) * 7'd10 + 7'(i_lsd));
        w_disp = w_val;
        o_pm   = 1'b0;
        if (i_mode) begin
            if (w_val == 7'd0) begin
                w_disp = 7'd12;
            end else if (w_val >= 7'd12) begin
                o_pm = 1'b1;
                if (w_val > 7'd12) begin
                    w_disp = w_val - 7'd12;
                end
            end
        end
        o_msd = MSD_W'(w_disp / 7'd10);
        o_lsd = 4'(w_disp % 7'd10);
    end
endmodule

// File: rtl/maq_hn.sv
// -----------------------------------------------------------------------------
// maq_hn : parametrised BCD hour stage, counts modulo DAY_MOD.
//   maqhn_clock : clock
//   reset       : asynchronous active-high reset
//   bus (slave) : tick qualifiers (enable_1hz, inc_m, inc_h), set_up/set_down,
//                 load/load_msd/load_lsd, mode_12h, alarm_set in;
//                 maqh_msd/maqh_lsd/pm display, carry_out, load_err,
//                 alarm_hit out.
//   Optional alarm compare enabled by defining MAQH_ALARM_EN; otherwise
//   alarm_set is ignored and alarm_hit is tied low.
// -----------------------------------------------------------------------------
module maq_hn
    import maq_pkg::*;
#(
    parameter int MSD_W   = 3,
    parameter int DAY_MOD = 24
) (
    input  logic     maqhn_clock,
    input  logic     reset,
    maq_hn_if.slave  bus
);
    localparam logic [7:0] MOD_B = 8'(DAY_MOD);
    localparam logic       IS_24 = (DAY_MOD == 24);

    logic [MSD_W-1:0] r_msd;
    bcd_t             r_lsd;
    logic             r_carry;
    logic             r_err;

    logic             w_tick;
    logic             w_load_ok;
    logic             w_err_any;
    op_e              w_op;
    bcd_pair_t        w_cur;
    bcd_pair_t        w_load_val;
    bcd_pair_t        w_next;
    logic             w_carry_nxt;
    logic             w_err_nxt;
    logic [MSD_W-1:0] w_disp_msd;
    bcd_t             w_disp_lsd;
    logic             w_pm;

    assign w_tick     = bus.enable_1hz & bus.inc_m & bus.inc_h;
    assign w_cur      = {4'(r_msd), r_lsd};
    assign w_load_val = {4'(bus.load_msd), bus.load_lsd};
    assign w_load_ok  = (bus.load_lsd <= BCD_MAX) && (bcd_val(w_load_val) <= MOD_B - 8'd1);

    // load > tick > exclusive set pulse; simultaneous up+down cancels.
    always_comb begin
        w_op = OP_NONE;
        if (bus.load) begin
            w_op = OP_LOAD;
        end else if (w_tick) begin
            w_op = OP_TICK;
        end else if (bus.set_up ^ bus.set_down) begin
            w_op = bus.set_up ? OP_UP : OP_DOWN;
        end
    end

    always_comb begin
        w_next      = w_cur;
        w_carry_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (w_op)
            OP_LOAD: begin
                if (w_load_ok) begin
                    w_next = w_load_val;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
            OP_TICK: begin
                w_next      = bcd_inc(w_cur, MOD_B);
                w_carry_nxt = (bcd_val(w_cur) == MOD_B - 8'd1);
            end
            OP_UP:   w_next = bcd_inc(w_cur, MOD_B);
            OP_DOWN: w_next = bcd_dec(w_cur, MOD_B);
            default: w_next = w_cur;
        endcase
    end

    always_ff @(posedge maqhn_clock or posedge reset) begin
        if (reset) begin
            r_msd   <= '0;
            r_lsd   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_msd   <= MSD_W'(w_next.msd);
            r_lsd   <= w_next.lsd;
            r_carry <= w_carry_nxt;
            r_err   <= w_err_any;
        end
    end

`ifdef MAQH_ALARM_EN
    logic [MSD_W-1:0] r_alm_msd;
    bcd_t             r_alm_lsd;
    logic             r_hit;
    logic             w_hit_nxt;

    // Only counting moves can hit; a load landing on the alarm value does not.
    assign w_hit_nxt = (w_op == OP_TICK || w_op == OP_UP || w_op == OP_DOWN) &&
                       (w_next == {4'(r_alm_msd), r_alm_lsd});
    assign w_err_any = w_err_nxt | (bus.alarm_set & ~w_load_ok);

    always_ff @(posedge maqhn_clock or posedge reset) begin
        if (reset) begin
            r_alm_msd <= '0;
            r_alm_lsd <= '0;
            r_hit     <= 1'b0;
        end else begin
            r_hit <= w_hit_nxt;
            if (bus.alarm_set && w_load_ok) begin
                r_alm_msd <= bus.load_msd;
                r_alm_lsd <= bus.load_lsd;
            end
        end
    end

    assign bus.alarm_hit = r_hit;
`else
    logic w_unused_alarm;
    assign w_unused_alarm = bus.alarm_set;
    assign w_err_any      = w_err_nxt;
    assign bus.alarm_hit  = 1'b0;
`endif

    maq_h12conv #(
        .MSD_W(MSD_W)
    ) u_conv (
        .i_msd  (r_msd),
        .i_lsd  (r_lsd),
        .i_mode (bus.mode_12h & IS_24),
        .o_msd  (w_disp_msd),
        .o_lsd  (w_disp_lsd),
        .o_pm   (w_pm)
    );

    assign bus.maqh_msd  = w_disp_msd;
    assign bus.maqh_lsd  = w_disp_lsd;
    assign bus.pm        = w_pm;
    assign bus.carry_out = r_carry;
    assign bus.load_err  = r_err;
endmodule

// File: tb/tb_maq_hn.sv
// -----------------------------------------------------------------------------
// tb_maq_hn : bench for maq_hn. Two instances (DAY_MOD=24 and DAY_MOD=12)
// share one stimulus stream; a plain-arithmetic hour model tracks each one.
// -----------------------------------------------------------------------------
module tb_maq_hn;
    logic clk;
    logic rst;

    logic       s_en, s_im, s_ih, s_up, s_dn, s_load, s_mode, s_aset;
    logic [2:0] s_lmsd;
    logic [3:0] s_llsd;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    maq_hn_if #(.MSD_W(3)) b24 ();
    maq_hn_if #(.MSD_W(2)) b12 ();

    assign b24.enable_1hz = s_en;
    assign b24.inc_m      = s_im;
    assign b24.inc_h      = s_ih;
    assign b24.set_up     = s_up;
    assign b24.set_down   = s_dn;
    assign b24.load       = s_load;
    assign b24.load_lsd   = s_llsd;
    assign b24.load_msd   = s_lmsd;
    assign b24.mode_12h   = s_mode;
    assign b24.alarm_set  = s_aset;

    assign b12.enable_1hz = s_en;
    assign b12.inc_m      = s_im;
    assign b12.inc_h      = s_ih;
    assign b12.set_up     = s_up;
    assign b12.set_down   = s_dn;
    assign b12.load       = s_load;
    assign b12.load_lsd   = s_llsd;
    assign b12.load_msd   = s_lmsd[1:0];
    assign b12.mode_12h   = s_mode;
    assign b12.alarm_set  = s_aset;

    maq_hn #(.MSD_W(3), .DAY_MOD(24)) u_dut24 (
        .maqhn_clock (clk),
        .reset       (rst),
        .bus         (b24)
    );

    maq_hn #(.MSD_W(2), .DAY_MOD(12)) u_dut12 (
        .maqhn_clock (clk),
        .reset       (rst),
        .bus         (b12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int mv [2];
    int ma [2];
    bit mc [2];
    bit me [2];
    bit mh [2];

    function automatic int modk(input int k);
        return (k == 0) ? 24 : 12;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mv[k] = 0; ma[k] = 0; mc[k] = 0; me[k] = 0; mh[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int lm, lv, nv, md;
                bit ok, moved;
                md    = modk(k);
                lm    = (k == 0) ? int'(s_lmsd) : int'(s_lmsd[1:0]);
                lv    = lm * 10 + int'(s_llsd);
                ok    = (int'(s_llsd) <= 9) && (lv < md);
                nv    = mv[k];
                moved = 0;
                mc[k] = 0;
                if (s_load) begin
                    if (ok) nv = lv;
                end else if (s_en && s_im && s_ih) begin
                    mc[k] = (mv[k] == md - 1);
                    nv    = (mv[k] + 1) % md;
                    moved = 1;
                end else if (s_up != s_dn) begin
                    nv    = s_up ? (mv[k] + 1) % md : (mv[k] + md - 1) % md;
                    moved = 1;
                end
                me[k] = s_load && !ok;
`ifdef MAQH_ALARM_EN
                mh[k] = moved && (nv == ma[k]);
                if (s_aset) begin
                    if (ok) ma[k] = lv;
                    else    me[k] = 1;
                end
`else
                mh[k] = 0;
`endif
                mv[k] = nv;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input int k, input int msd, input int lsd,
                            input int pm, input int cy, input int er, input int hit);
        int h, p;
        if (k == 0 && s_mode) begin
            h = mv[k] % 12;
            if (h == 0) h = 12;
            p = (mv[k] >= 12) ? 1 : 0;
        end else begin
            h = mv[k];
            p = 0;
        end
        chk({tag, "_msd"},   msd, h / 10);
        chk({tag, "_lsd"},   lsd, h % 10);
        chk({tag, "_pm"},    pm,  p);
        chk({tag, "_carry"}, cy,  int'(mc[k]));
        chk({tag, "_err"},   er,  int'(me[k]));
        chk({tag, "_hit"},   hit, int'(mh[k]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst("m24", 0, int'(b24.maqh_msd), int'(b24.maqh_lsd), int'(b24.pm),
                     int'(b24.carry_out), int'(b24.load_err), int'(b24.alarm_hit));
            cmp_inst("m12", 1, int'(b12.maqh_msd), int'(b12.maqh_lsd), int'(b12.pm),
                     int'(b12.carry_out), int'(b12.load_err), int'(b12.alarm_hit));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        s_en = 0; s_im = 0; s_ih = 0; s_up = 0; s_dn = 0;
        s_load = 0; s_aset = 0; s_lmsd = '0; s_llsd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int m, input int l);
        idle();
        s_load = 1; s_lmsd = 3'(m); s_llsd = 4'(l);
        step();
        idle();
    endtask

    task automatic do_tick();
        idle();
        s_en = 1; s_im = 1; s_ih = 1;
        step();
        idle();
    endtask

    task automatic lit24(input string name, input int m, input int l);
        chk({name, "_msd"}, int'(b24.maqh_msd), m);
        chk({name, "_lsd"}, int'(b24.maqh_lsd), l);
    endtask

    int sweep_v  [6] = '{0, 1, 11, 12, 13, 23};
    int sweep_d  [6] = '{12, 1, 11, 12, 1, 11};
    int sweep_pm [6] = '{0, 0, 0, 1, 1, 1};

    initial begin
        rst = 1;
        idle();
        s_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        lit24("rst", 0, 0);
        chk("rst_carry", int'(b24.carry_out), 0);
        chk("rst_err",   int'(b24.load_err), 0);
        rst = 0;
        chk_en = 1;

        // 23 -> tick wraps with carry
        do_load(2, 3);
        lit24("ld23", 2, 3);
        do_tick();
        lit24("wrap24", 0, 0);
        chk("wrap24_carry", int'(b24.carry_out), 1);
        step();
        chk("wrap24_carry_off", int'(b24.carry_out), 0);

        // 11 -> tick on the 12-hour instance
        do_load(1, 1);
        do_tick();
        chk("wrap12_msd", int'(b12.maqh_msd), 0);
        chk("wrap12_lsd", int'(b12.maqh_lsd), 0);
        chk("wrap12_carry", int'(b12.carry_out), 1);
        lit24("tick11", 1, 2);
        chk("tick11_carry", int'(b24.carry_out), 0);

        // down at 0, up at 9, up+down at 5
        do_load(0, 0);
        s_dn = 1; step(); idle();
        lit24("dn0", 2, 3);
        chk("dn0_carry", int'(b24.carry_out), 0);
        chk("dn0_12", int'(b12.maqh_lsd) + 10 * int'(b12.maqh_msd), 11);
        do_load(0, 9);
        s_up = 1; step(); idle();
        lit24("up9", 1, 0);
        do_load(0, 5);
        s_up = 1; s_dn = 1; step(); idle();
        lit24("updn", 0, 5);

        // rejected loads
        do_load(2, 7);
        lit24("rej27", 0, 5);
        chk("rej27_err", int'(b24.load_err), 1);
        step();
        chk("rej27_err_off", int'(b24.load_err), 0);
        do_load(0, 10);
        lit24("rejA", 0, 5);
        chk("rejA_err", int'(b24.load_err), 1);

        // 12h display sweep
        s_mode = 1;
        for (int i = 0; i < 6; i++) begin
            do_load(sweep_v[i] / 10, sweep_v[i] % 10);
            lit24($sformatf("h12_%0d", sweep_v[i]), sweep_d[i] / 10, sweep_d[i] % 10);
            chk($sformatf("h12_%0d_pm", sweep_v[i]), int'(b24.pm), sweep_pm[i]);
        end
        s_mode = 0;
        #1;
        lit24("mode_back", 2, 3);
        chk("mode_back_pm", int'(b24.pm), 0);

        // load beats tick at the wrap point
        idle();
        s_load = 1; s_lmsd = 3'd0; s_llsd = 4'd5;
        s_en = 1; s_im = 1; s_ih = 1;
        step(); idle();
        lit24("ldtick", 0, 5);
        chk("ldtick_carry", int'(b24.carry_out), 0);

        // alarm at 07
        idle();
        s_aset = 1; s_lmsd = 3'd0; s_llsd = 4'd7;
        step(); idle();
        do_load(0, 6);
        do_tick();
        lit24("alm_v", 0, 7);
`ifdef MAQH_ALARM_EN
        chk("alm_hit", int'(b24.alarm_hit), 1);
`else
        chk("alm_hit", int'(b24.alarm_hit), 0);
`endif
        do_tick();
        chk("alm_nohit", int'(b24.alarm_hit), 0);

        // asynchronous reset mid-count
        do_load(1, 5);
        do_tick();
        do_tick();
        lit24("pre_rst", 1, 7);
        #2 rst = 1;
        #1;
        lit24("async_rst", 0, 0);
        chk("async_rst_carry", int'(b24.carry_out), 0);
        step();
        rst = 0;
        do_load(2, 3);
        do_tick();
        chk("pend_carry", int'(b24.carry_out), 1);
        #2 rst = 1;
        #1;
        chk("pend_carry_clr", int'(b24.carry_out), 0);
        step();
        rst = 0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s_en   = 1'($urandom % 2);
            s_im   = ($urandom % 4) != 0;
            s_ih   = ($urandom % 4) != 0;
            s_up   = ($urandom % 5) == 0;
            s_dn   = ($urandom % 5) == 0;
            s_load = ($urandom % 8) == 0;
            s_aset = ($urandom % 16) == 0;
            s_lmsd = 3'($urandom_range(0, 3));
            s_llsd = 4'($urandom_range(0, 11));
            if (($urandom % 32) == 0) s_mode = ~s_mode;
            rst = ($urandom % 400) == 0;
            step();
        end
        rst = 0;
        idle();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
